// File: rtl/wb_regfile_pkg.sv
// Shared types and elaboration helpers for the Wishbone register-file slave.
package wb_regfile_pkg;

  // The widest supported port, so one response type serves every configuration.
  localparam int RESP_DATA_W = 64;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [RESP_DATA_W-1:0] data;
  } resp_t;

  function automatic bit params_legal(input int data_width, input int granule,
                                      input int latency, input int register_num,
                                      input int addr_width);
    bit ok;
    ok = (data_width == 8 || data_width == 16 || data_width == 32 || data_width == 64);
    ok &= (granule == 8 || granule == 16 || granule == 32 || granule == 64);
    ok &= (granule <= data_width) && (data_width % granule == 0);
    ok &= (latency >= 1) && (latency <= 4);
    ok &= (register_num >= 1) && (longint'(register_num) <= (longint'(1) << addr_width));
    return ok;
  endfunction

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-depth response delay line; a flush or reset empties every stage.
module wb_resp_pipe
  import wb_regfile_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  flush_i,
  input  resp_t resp_i,
  output resp_t resp_o
);

  resp_t stage_q [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the shift is order-independent.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= resp_i;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign resp_o = stage_q[STAGES-1];

endmodule

// File: rtl/wb_regfile_slave.sv
// Pipelined Wishbone register file: decode, RO/WO protection, register array
// with hardware write ports, and a fixed-latency response path.
module wb_regfile_slave
  import wb_regfile_pkg::*;
#(
  parameter int                          ADDR_WIDTH   = 16,
  parameter int                          DATA_WIDTH   = 32,
  parameter int                          GRANULE      = 8,
  parameter int                          REGISTER_NUM = 16,
  parameter int                          LATENCY      = 1,
  parameter logic [REGISTER_NUM-1:0]     RO_MASK      = '0,
  parameter logic [REGISTER_NUM-1:0]     WO_MASK      = '0,
  parameter logic [DATA_WIDTH-1:0]       RESET_VALUE  = '0,
  localparam int                         SEL_WIDTH    = DATA_WIDTH / GRANULE
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               cyc_i,
  input  logic                               stb_i,
  input  logic                               we_i,
  input  logic [ADDR_WIDTH-1:0]              adr_i,
  input  logic [DATA_WIDTH-1:0]              dat_i,
  input  logic [SEL_WIDTH-1:0]               sel_i,
  output logic [DATA_WIDTH-1:0]              dat_o,
  output logic                               ack_o,
  output logic                               err_o,
  output logic                               stall_o,
  input  logic [REGISTER_NUM-1:0]            hw_we_i,
  input  logic [REGISTER_NUM*DATA_WIDTH-1:0] hw_dat_i,
  output logic [REGISTER_NUM*DATA_WIDTH-1:0] regs_o
);

  if (!params_legal(DATA_WIDTH, GRANULE, LATENCY, REGISTER_NUM, ADDR_WIDTH)) begin : g_bad_params
    $error("wb_regfile_slave: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] regs_q [REGISTER_NUM];
  logic [DATA_WIDTH-1:0] regs_d [REGISTER_NUM];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] sel_mask;
  logic                  in_range, hit_ro, hit_wo, req_err, accept, bus_wr;
  logic                  init_q;
  resp_t                 resp_d, resp_q, pipe_out;

  // Stall covers the reset cycles themselves plus the first cycle after release.
  assign stall_o = ~rst_ni | init_q;
  assign accept  = cyc_i & stb_i & ~stall_o;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    in_range = 1'b0;
    hit_ro   = 1'b0;
    hit_wo   = 1'b0;
    rd_word  = '0;
    for (int k = 0; k < REGISTER_NUM; k++) begin
      if (adr_i == ADDR_WIDTH'(k)) begin
        in_range = 1'b1;
        hit_ro   = RO_MASK[k];
        hit_wo   = WO_MASK[k];
        rd_word  = regs_q[k];
      end
    end
    for (int g = 0; g < SEL_WIDTH; g++) sel_mask[g*GRANULE +: GRANULE] = {GRANULE{sel_i[g]}};
    req_err = ~in_range | (we_i & hit_ro) | (~we_i & hit_wo);
  end

  assign bus_wr = accept & we_i & ~req_err;

  // Hardware write lands first, then bus-selected granules override it.
  always_comb begin
    for (int k = 0; k < REGISTER_NUM; k++) begin
      regs_d[k] = hw_we_i[k] ? hw_dat_i[k*DATA_WIDTH +: DATA_WIDTH] : regs_q[k];
      if (bus_wr && adr_i == ADDR_WIDTH'(k)) begin
        regs_d[k] = (regs_d[k] & ~sel_mask) | (dat_i & sel_mask);
      end
    end
  end

  // NOTE: the register array is plain flops that must come up at a known
  // value, so it is reset explicitly rather than inferred as a RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < REGISTER_NUM; k++) regs_q[k] <= RESET_VALUE;
    end else begin
      for (int k = 0; k < REGISTER_NUM; k++) regs_q[k] <= regs_d[k];
    end
  end

  for (genvar k = 0; k < REGISTER_NUM; k++) begin : g_regs_out
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end

  // Read data is taken from pre-edge contents; writes and errors return zero.
  always_comb begin
    resp_d       = '0;
    resp_d.valid = accept;
    resp_d.err   = accept & req_err;
    if (accept && !we_i && !req_err) resp_d.data = RESP_DATA_W'(rd_word & sel_mask);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      init_q <= 1'b1;
      resp_q <= '0;
    end else begin
      init_q <= 1'b0;
      resp_q <= resp_d;
    end
  end

  wb_resp_pipe #(
    .STAGES (LATENCY)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (~cyc_i),
    .resp_i  (resp_q),
    .resp_o  (pipe_out)
  );

  assign ack_o = pipe_out.valid & ~pipe_out.err;
  assign err_o = pipe_out.valid & pipe_out.err;
  assign dat_o = pipe_out.data[DATA_WIDTH-1:0];

  logic unused_resp_data;
  assign unused_resp_data = ^pipe_out.data;

endmodule

// File: tb/tb_wb_regfile_slave.sv
// Directed bench for wb_regfile_slave: two instances differing only in LATENCY.
module tb_wb_regfile_slave;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RN = 16;
  localparam int SW = 4;
  localparam logic [RN-1:0] RO = 16'h0004;
  localparam logic [RN-1:0] WO = 16'h0020;
  localparam logic [DW-1:0] RV = 32'hA5A5_0000;

  logic           clk, rst_n;
  logic           cyc, stb, we;
  logic [AW-1:0]  adr;
  logic [DW-1:0]  dat;
  logic [SW-1:0]  sel;
  logic [RN-1:0]  hw_we;
  logic [RN*DW-1:0] hw_dat;

  logic [DW-1:0]    dat2, dat3;
  logic             ack2, ack3, err2, err3, stall2, stall3;
  logic [RN*DW-1:0] regs2, regs3;

  int checks = 0;
  int errors = 0;

  wb_regfile_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .REGISTER_NUM(RN), .LATENCY(2),
    .RO_MASK(RO), .WO_MASK(WO), .RESET_VALUE(RV)
  ) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat), .sel_i(sel), .dat_o(dat2), .ack_o(ack2), .err_o(err2), .stall_o(stall2),
    .hw_we_i(hw_we), .hw_dat_i(hw_dat), .regs_o(regs2)
  );

  wb_regfile_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .REGISTER_NUM(RN), .LATENCY(3),
    .RO_MASK(RO), .WO_MASK(WO), .RESET_VALUE(RV)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(dat), .sel_i(sel), .dat_o(dat3), .ack_o(ack3), .err_o(err3), .stall_o(stall3),
    .hw_we_i(hw_we), .hw_dat_i(hw_dat), .regs_o(regs3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s);
    stb = 1'b1; we = w; adr = a; dat = d; sel = s;
  endtask

  // One request, accepted at the next edge, then wait_cycles further edges.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input int wait_cycles);
    bus(w, a, d, s);
    tick();
    stb = 1'b0;
    repeat (wait_cycles) tick();
  endtask

  task automatic test_reset();
    int bad2, bad3;
    #1;
    checks++;
    if (stall2 !== 1'b1) begin errors++; $display("FAIL reset_stall_async: got %b expected 1", stall2); end
    repeat (3) tick();
    bad2 = 0; bad3 = 0;
    for (int k = 0; k < RN; k++) begin
      if (regs2[k*DW +: DW] !== RV) bad2++;
      if (regs3[k*DW +: DW] !== RV) bad3++;
    end
    checks++;
    if (bad2 != 0) begin errors++; $display("FAIL reset_regs_l2: %0d registers differ from %h", bad2, RV); end
    checks++;
    if (bad3 != 0) begin errors++; $display("FAIL reset_regs_l3: %0d registers differ from %h", bad3, RV); end
    checks++;
    if ({ack2, err2, ack3, err3} !== 4'b0000 || dat2 !== '0) begin
      errors++; $display("FAIL reset_outputs: ack/err=%b dat=%h expected 0000/0", {ack2, err2, ack3, err3}, dat2);
    end
    checks++;
    if (stall2 !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b expected 1", stall2); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (stall2 !== 1'b1) begin errors++; $display("FAIL stall_first_cycle: got %b expected 1", stall2); end
    tick();
    checks++;
    if ({stall2, stall3} !== 2'b00) begin errors++; $display("FAIL stall_release: got %b expected 00", {stall2, stall3}); end
    cyc = 1'b1;
  endtask

  task automatic test_latency();
    bus(1'b1, 3, 32'h1122_3344, 4'b0101);
    tick();
    bus(1'b0, 3, '0, 4'b0101);
    #1;
    checks++;
    if (stall2 !== 1'b0) begin errors++; $display("FAIL lat_no_stall: got %b expected 0", stall2); end
    tick();
    stb = 1'b0;
    checks++;
    if (ack2 !== 1'b0) begin errors++; $display("FAIL lat_early_ack: got %b expected 0", ack2); end
    checks++;
    if (regs2[3*DW +: DW] !== 32'hA522_0044) begin
      errors++; $display("FAIL lat_reg3: got %h expected a5220044", regs2[3*DW +: DW]);
    end
    tick();
    checks++;
    if ({ack2, err2} !== 2'b10 || dat2 !== '0) begin
      errors++; $display("FAIL lat_write_ack: ack/err=%b dat=%h expected 10/0", {ack2, err2}, dat2);
    end
    tick();
    checks++;
    if ({ack2, err2} !== 2'b10 || dat2 !== 32'h0022_0044) begin
      errors++; $display("FAIL lat_read_ack: ack/err=%b dat=%h expected 10/00220044", {ack2, err2}, dat2);
    end
    tick();
    checks++;
    if ({ack2, err2} !== 2'b00) begin errors++; $display("FAIL lat_ack_drop: got %b expected 00", {ack2, err2}); end
  endtask

  task automatic test_errors();
    send(1'b0, 16, '0, 4'hF, 2);
    checks++;
    if ({ack2, err2} !== 2'b01 || dat2 !== '0) begin
      errors++; $display("FAIL err_range: ack/err=%b dat=%h expected 01/0", {ack2, err2}, dat2);
    end
    send(1'b1, 2, 32'hDEAD_BEEF, 4'hF, 2);
    checks++;
    if ({ack2, err2} !== 2'b01) begin errors++; $display("FAIL err_ro_write: got %b expected 01", {ack2, err2}); end
    checks++;
    if (regs2[2*DW +: DW] !== RV) begin errors++; $display("FAIL err_ro_unchanged: got %h expected %h", regs2[2*DW +: DW], RV); end
    send(1'b0, 5, '0, 4'hF, 2);
    checks++;
    if ({ack2, err2} !== 2'b01 || dat2 !== '0) begin
      errors++; $display("FAIL err_wo_read: ack/err=%b dat=%h expected 01/0", {ack2, err2}, dat2);
    end
    send(1'b1, 5, 32'h0000_5555, 4'hF, 2);
    checks++;
    if ({ack2, err2} !== 2'b10) begin errors++; $display("FAIL wo_write_ack: got %b expected 10", {ack2, err2}); end
    checks++;
    if (regs2[5*DW +: DW] !== 32'h0000_5555) begin errors++; $display("FAIL wo_write_val: got %h expected 00005555", regs2[5*DW +: DW]); end
    send(1'b0, 2, '0, 4'hF, 2);
    checks++;
    if ({ack2, err2} !== 2'b10 || dat2 !== RV) begin
      errors++; $display("FAIL ro_read: ack/err=%b dat=%h expected 10/%h", {ack2, err2}, dat2, RV);
    end
    send(1'b1, 4, 32'hFFFF_FFFF, 4'h0, 2);
    checks++;
    if ({ack2, err2} !== 2'b10 || regs2[4*DW +: DW] !== RV) begin
      errors++; $display("FAIL sel0_write: ack/err=%b reg=%h expected 10/%h", {ack2, err2}, regs2[4*DW +: DW], RV);
    end
    send(1'b0, 4, '0, 4'h0, 2);
    checks++;
    if ({ack2, err2} !== 2'b10 || dat2 !== '0) begin
      errors++; $display("FAIL sel0_read: ack/err=%b dat=%h expected 10/0", {ack2, err2}, dat2);
    end
    tick();
  endtask

  task automatic test_collision();
    hw_we[7] = 1'b1;
    hw_dat[7*DW +: DW] = 32'hFFFF_FFFF;
    bus(1'b1, 7, 32'h0000_0000, 4'b0011);
    tick();
    hw_we = '0; stb = 1'b0;
    checks++;
    if (regs2[7*DW +: DW] !== 32'hFFFF_0000) begin errors++; $display("FAIL collision: got %h expected ffff0000", regs2[7*DW +: DW]); end
    hw_we[2] = 1'b1;
    hw_dat[2*DW +: DW] = 32'h1234_5678;
    tick();
    hw_we = '0;
    checks++;
    if (regs2[2*DW +: DW] !== 32'h1234_5678) begin errors++; $display("FAIL hw_write_ro: got %h expected 12345678", regs2[2*DW +: DW]); end
    hw_we[7] = 1'b1;
    hw_dat[7*DW +: DW] = 32'h0BAD_F00D;
    bus(1'b0, 7, '0, 4'hF);
    tick();
    hw_we = '0; stb = 1'b0;
    checks++;
    if (regs2[7*DW +: DW] !== 32'h0BAD_F00D) begin errors++; $display("FAIL hw_write: got %h expected 0badf00d", regs2[7*DW +: DW]); end
    repeat (2) tick();
    checks++;
    if ({ack2, err2} !== 2'b10 || dat2 !== 32'hFFFF_0000) begin
      errors++; $display("FAIL read_vs_hw: ack/err=%b dat=%h expected 10/ffff0000", {ack2, err2}, dat2);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic          r_we  [4];
    logic [AW-1:0] r_adr [4];
    logic [DW-1:0] r_dat [4];
    logic [DW-1:0] r_exp [4];
    r_we  = '{1'b1, 1'b1, 1'b0, 1'b0};
    r_adr = '{16'd11, 16'd12, 16'd11, 16'd12};
    r_dat = '{32'hCAFE_0011, 32'hCAFE_0012, 32'h0, 32'h0};
    r_exp = '{32'h0, 32'h0, 32'hCAFE_0011, 32'hCAFE_0012};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus(r_we[i], r_adr[i], r_dat[i], 4'hF);
        #1;
        checks++;
        if (stall2 !== 1'b0) begin errors++; $display("FAIL b2b_stall[%0d]: got %b expected 0", i, stall2); end
      end else begin
        stb = 1'b0;
      end
      tick();
      if (i >= 2) begin
        checks++;
        if ({ack2, err2} !== 2'b10 || dat2 !== r_exp[i-2]) begin
          errors++; $display("FAIL b2b_resp[%0d]: ack/err=%b dat=%h expected 10/%h", i-2, {ack2, err2}, dat2, r_exp[i-2]);
        end
      end
    end
    tick();
    checks++;
    if ({ack2, err2} !== 2'b00) begin errors++; $display("FAIL b2b_drain: got %b expected 00", {ack2, err2}); end
  endtask

  task automatic test_flush();
    int seen;
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, AW'(8 + i), {4{8'(8'h11 * (i + 1))}}, 4'hF);
      tick();
    end
    stb = 1'b0; cyc = 1'b0;
    seen = 0;
    tick();
    cyc = 1'b1;
    if (ack3 || err3) seen++;
    repeat (4) begin
      tick();
      if (ack3 || err3) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_no_resp: got %0d responses expected 0", seen); end
    checks++;
    if (regs3[8*DW +: DW] !== 32'h1111_1111 || regs3[9*DW +: DW] !== 32'h2222_2222 ||
        regs3[10*DW +: DW] !== 32'h3333_3333) begin
      errors++; $display("FAIL flush_writes: got %h %h %h expected 11111111 22222222 33333333",
                         regs3[8*DW +: DW], regs3[9*DW +: DW], regs3[10*DW +: DW]);
    end
    send(1'b0, 9, '0, 4'hF, 3);
    checks++;
    if ({ack3, err3} !== 2'b10 || dat3 !== 32'h2222_2222) begin
      errors++; $display("FAIL post_flush_read: ack/err=%b dat=%h expected 10/22222222", {ack3, err3}, dat3);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    int bad, seen;
    bus(1'b0, 8, '0, 4'hF);
    tick();
    bus(1'b0, 9, '0, 4'hF);
    tick();
    stb = 1'b0; rst_n = 1'b0;
    #1;
    checks++;
    if (stall3 !== 1'b1) begin errors++; $display("FAIL mid_stall_1: got %b expected 1", stall3); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (stall3 !== 1'b1) begin errors++; $display("FAIL mid_stall_2: got %b expected 1", stall3); end
    bad = 0;
    for (int k = 0; k < RN; k++) if (regs3[k*DW +: DW] !== RV) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_regs: %0d registers differ from %h", bad, RV); end
    seen = 0;
    if (ack3 || err3) seen++;
    tick();
    checks++;
    if (stall3 !== 1'b0) begin errors++; $display("FAIL mid_stall_3: got %b expected 0", stall3); end
    if (ack3 || err3) seen++;
    repeat (3) begin
      tick();
      if (ack3 || err3) seen++;
    end
    checks++;
    if (seen != 0 || dat3 !== '0) begin
      errors++; $display("FAIL mid_no_resp: got %0d responses dat=%h expected 0/0", seen, dat3);
    end
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat = '0; sel = '0; hw_we = '0; hw_dat = '0;
    test_reset();
    test_latency();
    test_errors();
    test_collision();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
